// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the byte-wide RAM port arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic              RESET_ENABLE  = 1'b1;
  localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM requester, stall and RAM port signals of the arbiter
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_data;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic              stallreq_if;
  logic              stallreq_mem;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  ram_din,
    output if_done, if_data, mem_done, mem_rdata,
    output stallreq_if, stallreq_mem,
    output ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output ram_din,
    input  if_done, if_data, mem_done, mem_rdata,
    input  stallreq_if, stallreq_mem,
    input  ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one byte-wide RAM port between IF and MEM, serialising 1/2/4-byte accesses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  state_t            state, state_nx;
  owner_t            owner;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n_bytes;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic [1:0]        cap_lane;
  logic              rd_active;
  logic              capture;

  logic [ADDR_W-1:0] ram_a_c;
  logic              ram_wr_c;
  logic [7:0]        ram_dout_c;
  logic              if_done_c;
  logic              mem_done_c;

  function automatic logic [DATA_W-1:0] lane_insert(input logic [DATA_W-1:0] word,
                                                    input logic [7:0] b,
                                                    input logic [1:0] lane);
    logic [DATA_W-1:0] w;
    w = word;
    w[8*lane +: 8] = b;
    return w;
  endfunction

  function automatic logic [7:0] lane_extract(input logic [DATA_W-1:0] word,
                                              input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

  // Read data trails its address by one cycle, so the byte seen at cnt belongs to lane cnt-1.
  assign rd_active = (state == ST_IF_RD) || (state == ST_MEM_RD);
  assign cap_lane  = cnt[1:0] - 2'd1;
  assign capture   = rd_active && (cnt != 3'd0) && !((state == ST_IF_RD) && bus.if_flush);
  assign asm_next  = lane_insert(asm_word, bus.ram_din, cap_lane);

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state       <= ST_IDLE;
      owner       <= OWN_IF;
      base        <= '0;
      n_bytes     <= 3'd0;
      cnt         <= 3'd0;
      wdata       <= ZERO_WORD;
      asm_word    <= ZERO_WORD;
      if_data_q   <= ZERO_WORD;
      mem_rdata_q <= ZERO_WORD;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) begin
        cnt      <= 3'd0;
        asm_word <= ZERO_WORD;
        if (bus.mem_req) begin
          owner   <= OWN_MEM;
          base    <= bus.mem_addr;
          n_bytes <= len_bytes(bus.mem_len);
          wdata   <= bus.mem_wdata;
        end else if (bus.if_req && !bus.if_flush) begin
          owner   <= OWN_IF;
          base    <= bus.if_addr;
          n_bytes <= 3'd4;
        end
      end else if (state != ST_DONE) begin
        cnt <= cnt + 3'd1;
      end
      if (capture) begin
        asm_word <= asm_next;
        if (cnt == n_bytes) begin
          if (state == ST_IF_RD) if_data_q <= asm_next;
          else                   mem_rdata_q <= asm_next;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.mem_req)                       state_nx = bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
        else if (bus.if_req && !bus.if_flush)  state_nx = ST_IF_RD;
      end
      ST_IF_RD: begin
        if (bus.if_flush)          state_nx = ST_IDLE;
        else if (cnt == n_bytes)   state_nx = ST_DONE;
      end
      ST_MEM_RD: if (cnt == n_bytes)         state_nx = ST_DONE;
      ST_MEM_WR: if (cnt == n_bytes - 3'd1)  state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_a_c    = '0;
    ram_wr_c   = WRITE_DISABLE;
    ram_dout_c = 8'h00;
    if_done_c  = 1'b0;
    mem_done_c = 1'b0;
    case (state)
      ST_IF_RD, ST_MEM_RD: begin
        if (cnt < n_bytes) ram_a_c = base + {{(ADDR_W-3){1'b0}}, cnt};
      end
      ST_MEM_WR: begin
        ram_a_c    = base + {{(ADDR_W-3){1'b0}}, cnt};
        ram_wr_c   = WRITE_ENABLE;
        ram_dout_c = lane_extract(wdata, cnt[1:0]);
      end
      ST_DONE: begin
        if_done_c  = (owner == OWN_IF) && !bus.if_flush;
        mem_done_c = (owner == OWN_MEM);
      end
      default: ;
    endcase
  end

  assign bus.ram_a        = ram_a_c;
  assign bus.ram_wr       = ram_wr_c;
  assign bus.ram_dout     = ram_dout_c;
  assign bus.if_done      = if_done_c;
  assign bus.mem_done     = mem_done_c;
  assign bus.if_data      = if_data_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.stallreq_if  = bus.if_req && !if_done_c;
  assign bus.stallreq_mem = bus.mem_req && !mem_done_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a byte RAM and shadow memory model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0]  ram    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_rdata;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM: one-cycle read latency, plus a backdoor used only for preloading.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.ram_wr) ram[bus.ram_a[15:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    shadow[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_ram_a", bus.ram_a, 32'h0);
    check("idle_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
    check("idle_if_done", {31'h0, bus.if_done}, 32'h0);
    check("idle_mem_done", {31'h0, bus.mem_done}, 32'h0);
  endtask

  task automatic drive_if(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic drive_mem(input bit we, input logic [1:0] len, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_len   = len;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
  endtask

  // Reference: N byte cycles at base+i, done N+1 cycles (read) or N cycles (write) after acceptance.
  task automatic observe(input bit is_if, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit if_waiting, input bit hold);
    int n;
    int lat;
    logic [31:0] exp_rd;
    n = is_if ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
    lat = we ? n : n + 1;
    exp_rd = 32'h0;
    for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = shadow[16'(addr + 32'(i))];
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k < n) begin
        check("ram_a", bus.ram_a, addr + 32'(k));
        check("ram_wr", {31'h0, bus.ram_wr}, {31'h0, we});
        if (we) check("ram_dout", {24'h0, bus.ram_dout}, {24'h0, wd[8*k +: 8]});
      end else begin
        check("ram_a_gap", bus.ram_a, 32'h0);
        check("ram_wr_gap", {31'h0, bus.ram_wr}, 32'h0);
      end
      if (is_if) begin
        check("if_done", {31'h0, bus.if_done}, {31'h0, k == lat});
        check("stallreq_if", {31'h0, bus.stallreq_if}, {31'h0, k != lat});
        check("mem_done_quiet", {31'h0, bus.mem_done}, 32'h0);
      end else begin
        check("mem_done", {31'h0, bus.mem_done}, {31'h0, k == lat});
        check("stallreq_mem", {31'h0, bus.stallreq_mem}, {31'h0, k != lat});
        check("if_done_quiet", {31'h0, bus.if_done}, 32'h0);
        if (if_waiting) check("stallreq_if_wait", {31'h0, bus.stallreq_if}, 32'h1);
      end
    end
    if (is_if) begin
      exp_if_data = exp_rd;
      check("if_data", bus.if_data, exp_if_data);
      if (!hold) bus.if_req = 1'b0;
    end else begin
      if (we) begin
        for (int i = 0; i < n; i++) shadow[16'(addr + 32'(i))] = wd[8*i +: 8];
      end else begin
        exp_mem_rdata = exp_rd;
      end
      check("mem_rdata", bus.mem_rdata, exp_mem_rdata);
      if (!hold) bus.mem_req = 1'b0;
    end
  endtask

  initial begin
    int sel;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wd;

    checks = 0;
    errors = 0;
    exp_if_data = 32'h0;
    exp_mem_rdata = 32'h0;
    rst = 1'b1;
    bd_we = 1'b0;
    bd_addr = 16'h0;
    bd_data = 8'h0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;
    bus.if_flush = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_len = 2'b00;
    bus.mem_addr = 32'h0;
    bus.mem_wdata = 32'h0;

    // Preload under reset
    @(negedge clk);
    for (int a = 0; a < 32'h300; a++) bd_write(16'(a), 8'($urandom));
    for (int a = 32'hFFFC; a <= 32'hFFFF; a++) bd_write(16'(a), 8'($urandom));
    bd_write(16'h0100, 8'h13);
    bd_write(16'h0101, 8'h05);
    bd_write(16'h0102, 8'h50);
    bd_write(16'h0103, 8'h00);
    bd_write(16'h0010, 8'h34);
    bd_write(16'h0011, 8'h12);

    check("rst_ram_a", bus.ram_a, 32'h0);
    check("rst_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
    check("rst_ram_dout", {24'h0, bus.ram_dout}, 32'h0);
    check("rst_if_done", {31'h0, bus.if_done}, 32'h0);
    check("rst_mem_done", {31'h0, bus.mem_done}, 32'h0);
    check("rst_if_data", bus.if_data, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;

    // IF word read
    idle_cycle();
    drive_if(32'h100);
    observe(1'b1, 1'b0, LEN_WORD, 32'h100, 32'h0, 1'b0, 1'b0);
    check("t1_if_data_const", bus.if_data, 32'h0050_0513);

    // Store byte
    idle_cycle();
    drive_mem(1'b1, LEN_BYTE, 32'h2003, 32'hAABB_CCDD);
    observe(1'b0, 1'b1, LEN_BYTE, 32'h2003, 32'hAABB_CCDD, 1'b0, 1'b0);

    // Load half
    idle_cycle();
    drive_mem(1'b0, LEN_HALF, 32'h10, 32'h0);
    observe(1'b0, 1'b0, LEN_HALF, 32'h10, 32'h0, 1'b0, 1'b0);
    check("t3_rdata_const", bus.mem_rdata, 32'h0000_1234);

    // Flush held during a MEM access has no effect on it
    idle_cycle();
    bus.if_flush = 1'b1;
    drive_mem(1'b0, LEN_WORD, 32'h100, 32'h0);
    observe(1'b0, 1'b0, LEN_WORD, 32'h100, 32'h0, 1'b0, 1'b0);
    bus.if_flush = 1'b0;

    // Simultaneous requests: MEM first, IF stalled throughout
    idle_cycle();
    drive_mem(1'b1, LEN_HALF, 32'h40, 32'h0000_BEEF);
    drive_if(32'h40);
    observe(1'b0, 1'b1, LEN_HALF, 32'h40, 32'h0000_BEEF, 1'b1, 1'b0);
    idle_cycle();
    check("t4_stall_if_idle", {31'h0, bus.stallreq_if}, 32'h1);
    observe(1'b1, 1'b0, LEN_WORD, 32'h40, 32'h0, 1'b0, 1'b0);

    // Flush in IF_RD cycle 2
    idle_cycle();
    drive_if(32'h180);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_ram_a", bus.ram_a, 32'h180 + 32'(k));
    end
    bus.if_flush = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t5_ram_a_idle", bus.ram_a, 32'h0);
    check("t5_ram_wr_idle", {31'h0, bus.ram_wr}, 32'h0);
    check("t5_no_if_done", {31'h0, bus.if_done}, 32'h0);
    check("t5_if_data_held", bus.if_data, exp_if_data);
    bus.if_flush = 1'b0;
    idle_cycle();
    idle_cycle();
    drive_if(32'h200);
    observe(1'b1, 1'b0, LEN_WORD, 32'h200, 32'h0, 1'b0, 1'b0);

    // Reset during MEM_WR cycle 1
    idle_cycle();
    drive_mem(1'b1, LEN_WORD, 32'h8000, 32'h1122_3344);
    @(negedge clk);
    check("t6_wr_c0", {31'h0, bus.ram_wr}, 32'h1);
    @(negedge clk);
    check("t6_ram_a_c1", bus.ram_a, 32'h8001);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
    check("t6_ram_a", bus.ram_a, 32'h0);
    check("t6_mem_done", {31'h0, bus.mem_done}, 32'h0);
    check("t6_if_done", {31'h0, bus.if_done}, 32'h0);
    check("t6_if_data", bus.if_data, 32'h0);
    check("t6_mem_rdata", bus.mem_rdata, 32'h0);
    exp_if_data = 32'h0;
    exp_mem_rdata = 32'h0;
    rst = 1'b0;
    bus.mem_req = 1'b0;
    idle_cycle();

    // if_req held through DONE must not start a second fetch
    drive_if(32'h104);
    observe(1'b1, 1'b0, LEN_WORD, 32'h104, 32'h0, 1'b0, 1'b1);
    idle_cycle();
    check("nohold_stall", {31'h0, bus.stallreq_if}, 32'h1);
    bus.if_req = 1'b0;
    idle_cycle();

    // Random accesses, including address wrap
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 2);
      len = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           addr = 32'($urandom_range(0, 32'h2F8));
      wd = $urandom;
      repeat ($urandom_range(0, 2)) idle_cycle();
      if (sel == 0) begin
        drive_if(addr);
        observe(1'b1, 1'b0, LEN_WORD, addr, 32'h0, 1'b0, 1'b0);
      end else begin
        drive_mem(sel == 2, len, addr, wd);
        observe(1'b0, sel == 2, len, addr, wd, 1'b0, 1'b0);
      end
      idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
